// File: rtl/store_buffer_fifo.sv
// Circular store buffer: in-order drain, same-word coalescing into the youngest cached entry,
// zero-cycle byte-accurate youngest-wins load forwarding. One-cycle push-to-head latency.
module store_buffer_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W/8-1:0]      in_wen,
  input  logic                     in_uncache,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [DATA_W/8-1:0]      out_wen,
  output logic                     out_uncache,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [DATA_W/8-1:0]      ld_hit_mask,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_uncache_conflict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int BE  = DATA_W / 8;
  localparam int OFF = $clog2(BE);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE-1:0]     wen;
    logic              unc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   young;
  logic            pop, coal, alloc, merge;
  logic [PW-1:0]   fidx;
  entry_t          fe;
  logic            unused_ld_off;

  assign young         = tail_q - PW'(1);
  assign count         = count_q;
  assign unused_ld_off = ^ld_addr[OFF-1:0];

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    out_valid = !empty && !flush;
    pop       = out_valid && out_ready;
    // Never merge into an entry that is leaving this cycle.
    coal      = in_valid && !in_uncache && !empty && !mem_q[young].unc &&
                (in_addr[ADDR_W-1:OFF] == mem_q[young].addr[ADDR_W-1:OFF]) &&
                !(count_q == CW'(1) && pop);
    in_ready  = !flush && (!full || pop || coal);
    alloc     = in_valid && in_ready && !coal;
    merge     = in_valid && in_ready && coal;
  end

  always_comb begin
    out_addr    = empty ? '0 : mem_q[head_q].addr;
    out_data    = empty ? '0 : mem_q[head_q].data;
    out_wen     = empty ? '0 : mem_q[head_q].wen;
    out_uncache = empty ? 1'b0 : mem_q[head_q].unc;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) head_d = head_q + PW'(1);
      if (alloc) begin
        mem_d[tail_q] = '{addr: in_addr, data: in_data, wen: in_wen, unc: in_uncache};
        tail_d        = tail_q + PW'(1);
      end
      if (merge) begin
        for (int b = 0; b < BE; b++) begin
          if (in_wen[b]) mem_d[young].data[8*b +: 8] = in_data[8*b +: 8];
        end
        mem_d[young].wen = mem_q[young].wen | in_wen;
      end
      count_d = count_q + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Walk oldest to youngest so later matches overwrite earlier ones per byte.
  always_comb begin
    ld_hit_mask         = '0;
    ld_data             = '0;
    ld_uncache_conflict = 1'b0;
    fidx                = '0;
    fe                  = '0;
    if (ld_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        fidx = head_q + PW'(k);
        fe   = mem_q[fidx];
        if ((CW'(k) < count_q) && (fe.addr[ADDR_W-1:OFF] == ld_addr[ADDR_W-1:OFF])) begin
          if (fe.unc) begin
            ld_uncache_conflict = 1'b1;
          end else begin
            for (int b = 0; b < BE; b++) begin
              if (fe.wen[b]) begin
                ld_hit_mask[b]     = 1'b1;
                ld_data[8*b +: 8]  = fe.data[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_fifo.sv
// Directed bench for store_buffer_fifo: stimulus queues expected drains, a negedge monitor checks them.
module tb_store_buffer_fifo;

  logic        clk = 1'b0;
  logic        rst_, flush, in_valid, in_ready, in_uncache;
  logic [31:0] in_addr, in_data;
  logic [3:0]  in_wen;
  logic        out_valid, out_ready, out_uncache;
  logic [31:0] out_addr, out_data;
  logic [3:0]  out_wen;
  logic        ld_en, ld_uncache_conflict;
  logic [31:0] ld_addr, ld_data;
  logic [3:0]  ld_hit_mask;
  logic [3:0]  count;
  logic        empty, full;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wen;
    logic        unc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  store_buffer_fifo #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_(rst_), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .in_wen(in_wen), .in_uncache(in_uncache),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_wen(out_wen), .out_uncache(out_uncache),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_hit_mask(ld_hit_mask), .ld_data(ld_data),
    .ld_uncache_conflict(ld_uncache_conflict),
    .count(count), .empty(empty), .full(full)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic u);
    exp_q.push_back('{addr: a, data: d, wen: w, unc: u});
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic u);
    in_valid = 1'b1; in_addr = a; in_data = d; in_wen = w; in_uncache = u;
    @(negedge clk);
    check("push_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (empty) begin done = 1; break; end
    end
    check(name, done, 1);
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_ && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got addr %h expected no output", out_addr);
      end else begin
        e = exp_q.pop_front();
        check("out_addr", out_addr, e.addr);
        check("out_data", out_data, e.data);
        check("out_wen", out_wen, e.wen);
        check("out_uncache", out_uncache, e.unc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1; flush = 0; in_valid = 0; in_addr = 0; in_data = 0; in_wen = 0; in_uncache = 0;
    out_ready = 0; ld_en = 1; ld_addr = 32'h100;
    step(); step();
    rst_ = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_ld_mask", ld_hit_mask, 0);
    step();

    // In-order drain of four independent words.
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 0);
      exp_push(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 0);
    end
    @(negedge clk);
    check("fill4_count", count, 4);
    check("fill4_out_valid", out_valid, 1);
    step();
    out_ready = 1;
    wait_empty("drain4_empty");
    out_ready = 0;

    // Coalesce into a single entry.
    push(32'h200, 32'h0000_00AA, 4'b0001, 0);
    push(32'h202, 32'h00BB_0000, 4'b0100, 0);
    exp_push(32'h200, 32'h00BB_00AA, 4'b0101, 0);
    ld_en = 1; ld_addr = 32'h200;
    @(negedge clk);
    check("coal_count", count, 1);
    check("coal_head_data", out_data, 32'h00BB_00AA);
    check("coal_head_wen", out_wen, 4'b0101);
    check("coal_ld_mask", ld_hit_mask, 4'b0101);
    check("coal_ld_data", ld_data, 32'h00BB_00AA);
    step();
    ld_en = 0;
    @(negedge clk);
    check("ld_dis_mask", ld_hit_mask, 0);
    check("ld_dis_data", ld_data, 0);
    step();
    out_ready = 1;
    wait_empty("coal_drain_empty");
    out_ready = 0;

    // Fill to full across pointer wrap, then pop+alloc while full.
    for (int i = 0; i < 8; i++) begin
      push(32'h500 + 32'(4*i), 32'h5000_0000 + 32'(i), 4'hF, 0);
      exp_push(32'h500 + 32'(4*i), 32'h5000_0000 + 32'(i), 4'hF, 0);
    end
    in_valid = 1; in_addr = 32'h600; in_data = 32'h6000_0000; in_wen = 4'hF; in_uncache = 0;
    @(negedge clk);
    check("full_flag", full, 1);
    check("full_in_ready", in_ready, 0);
    step();
    out_ready = 1;
    exp_push(32'h600, 32'h6000_0000, 4'hF, 0);
    @(negedge clk);
    check("full_pop_in_ready", in_ready, 1);
    step();
    in_addr = 32'h604; in_data = 32'h6000_0004;
    exp_push(32'h604, 32'h6000_0004, 4'hF, 0);
    @(negedge clk);
    check("full_swap_count", count, 8);
    step();
    in_valid = 0;
    wait_empty("wrap_drain_empty");
    out_ready = 0;

    // Youngest-wins forwarding around an uncached entry.
    push(32'h300, 32'h1111_1111, 4'hF, 0);
    push(32'h400, 32'hDEAD_BEEF, 4'hF, 1);
    push(32'h300, 32'h2200_0000, 4'b1000, 0);
    exp_push(32'h300, 32'h1111_1111, 4'hF, 0);
    exp_push(32'h400, 32'hDEAD_BEEF, 4'hF, 1);
    exp_push(32'h300, 32'h2200_0000, 4'b1000, 0);
    ld_en = 1; ld_addr = 32'h300;
    @(negedge clk);
    check("unc_count", count, 3);
    check("fwd300_mask", ld_hit_mask, 4'hF);
    check("fwd300_data", ld_data, 32'h2211_1111);
    check("fwd300_conflict", ld_uncache_conflict, 0);
    step();
    ld_addr = 32'h400;
    @(negedge clk);
    check("fwd400_mask", ld_hit_mask, 0);
    check("fwd400_data", ld_data, 0);
    check("fwd400_conflict", ld_uncache_conflict, 1);
    step();
    ld_en = 0;
    out_ready = 1;
    wait_empty("unc_drain_empty");
    out_ready = 0;

    // Flush with a pop pending and a store offered.
    for (int i = 0; i < 5; i++) push(32'h700 + 32'(4*i), 32'h7000_0000 + 32'(i), 4'hF, 0);
    flush = 1; out_ready = 1;
    in_valid = 1; in_addr = 32'h800; in_data = 32'h8000_0000; in_wen = 4'hF; in_uncache = 0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    check("post_flush_count", count, 0);
    check("post_flush_out_valid", out_valid, 0);
    check("post_flush_empty", empty, 1);
    step(); step();
    out_ready = 0;

    // Synchronous reset mid-drain.
    for (int i = 0; i < 3; i++) begin
      push(32'h900 + 32'(4*i), 32'h9000_0000 + 32'(i), 4'hF, 0);
      exp_push(32'h900 + 32'(4*i), 32'h9000_0000 + 32'(i), 4'hF, 0);
    end
    out_ready = 1;
    step();
    rst_ = 1;
    exp_q.delete();
    step();
    rst_ = 0; ld_en = 1; ld_addr = 32'h904;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_wen", out_wen, 0);
    check("mid_rst_ld_mask", ld_hit_mask, 0);
    check("mid_rst_ld_data", ld_data, 0);
    check("mid_rst_conflict", ld_uncache_conflict, 0);
    step(); step(); step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer_fifo.md
# store_buffer_fifo

Parametrised circular store buffer between the LSU store path and the data cache / uncached bridge. Accepts byte-enabled stores, drains them in program order through a valid/ready port, and coalesces a cached store into the youngest entry when both target the same word. It also answers same-cycle load lookups with per-byte forwarding. Successor to the fixed 16-entry shift-register buffer: depth and width are generic, pointers replace shifting, and forwarding is byte-accurate with youngest-wins priority.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, data width; multiple of 8; BE = DATA_W/8; OFF = log2(BE)
- clk  input  1  clock; all state on rising edge
- rst_  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all entries
- in_valid  input  1  store request
- in_ready  output  1  store accepted when in_valid && in_ready
- in_addr  input  ADDR_W  store byte address
- in_data  input  DATA_W  store data, lane-aligned
- in_wen  input  BE  byte enables
- in_uncache  input  1  uncached store; never coalesced or forwarded
- out_valid  output  1  head entry present
- out_ready  input  1  cache/bridge takes head when out_valid && out_ready
- out_addr / out_data / out_wen / out_uncache  output  ADDR_W / DATA_W / BE / 1  head entry fields
- ld_en  input  1  load lookup enable
- ld_addr  input  ADDR_W  load address; word compare on [ADDR_W-1:OFF]
- ld_hit_mask  output  BE  bytes supplied by the buffer
- ld_data  output  DATA_W  forwarded bytes; non-hit lanes 0
- ld_uncache_conflict  output  1  a matching entry is uncached
- count  output  log2(DEPTH)+1  occupied entries
- empty / full  output  1 / 1  count==0 / count==DEPTH

## Operation
- Storage: DEPTH entries {addr, data, wen, uncache}. head = oldest, tail = next free. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is held separately.
- pop = out_valid && out_ready. out_valid = !empty && !flush.
- Coalesce condition (coal):
  - in_valid && !in_uncache && !empty
  - youngest entry (tail-1) is cached
  - word address of in_addr equals word address of youngest entry
  - !(count==1 && pop)
- Coalesce action: for each byte b with in_wen[b] set, youngest data byte b ← in_data byte b. Youngest wen ← wen | in_wen. The address is unchanged, count is unchanged and tail does not move.
- Allocate (alloc = in_valid && in_ready && !coal): write entry at tail, tail+1, count+1.
- in_ready = !flush && (!full || pop || coal).
- A simultaneous alloc and pop leaves count unchanged. When full, an alloc in the same cycle as a pop is legal.
- flush: head, tail and count go to 0; the in/out handshakes are suppressed that cycle; entry contents are don't-care. Priority is rst_ > flush > push/pop.
- Forwarding (combinational, ld_en=1), per byte b:
  - Candidates are valid cached entries with a word-address match and wen[b]=1.
  - The youngest candidate supplies byte b and sets ld_hit_mask[b].
  - Uncached entries never supply data; a word-address match on one sets ld_uncache_conflict.
  - The store being accepted in the same cycle is not visible to the lookup.
  - With ld_en=0, all ld_* outputs are 0.
- Age ordering is over the entries from head to tail-1 modulo DEPTH and must be correct across pointer wrap.

## Timing
- Reset values: in_ready=1, out_valid=0, out_addr/out_data/out_wen/out_uncache=0, count=0, empty=1, full=0, ld_hit_mask=0, ld_data=0, ld_uncache_conflict=0.
- Latency:
  - Push to out_valid is 1 cycle: an accepted store into an empty buffer presents at the head next cycle.
  - A coalesce is reflected at the head/forwarding the next cycle.
- Forwarding is zero-cycle: ld_* are valid in the same cycle as ld_addr and depend only on registered state.
- out_* fields hold stable while out_valid && !out_ready. The head is never modified by a coalesce except when it is also the youngest and no pop occurs.
- in_ready depends combinationally on out_ready and in_* (coal). The consumer must not make out_ready depend on in_ready.
- rst_ or flush mid-stream: the next cycle shows the reset values for out_valid, count, empty and full. Dropped entries never appear at out_*.

## Test plan
- Reset, then push 4 cached stores to 0x100, 0x104, 0x108, 0x10C with out_ready=0 → count=4. Then out_ready=1 → drain in order over 4 cycles, empty=1 after.
- Push {0x200, data 0x000000AA, wen 0001}, then {0x202, 0x00BB0000, wen 0100} → count=1, head data 0x00BB00AA, wen 0101. A load at 0x200 → ld_hit_mask=0101, ld_data=0x00BB00AA.
- Fill DEPTH=8 with out_ready=0 → full=1, in_ready=0 for a non-coalescing store. Then out_ready=1 with in_valid → pop and alloc in the same cycle, count stays 8; verify ordering across pointer wrap.
- Older 0x300 = 0x11111111 wen 1111, then an uncached store to 0x400, then a newer cached 0x300 = 0x22000000 wen 1000 (not coalesced, because the youngest entry is uncached when it arrives). Load 0x300 → ld_hit_mask=1111, ld_data=0x22111111. Load 0x400 → ld_hit_mask=0, ld_uncache_conflict=1.
- With 5 entries and pop pending, assert flush → next cycle count=0, out_valid=0, no handshake in the flush cycle. Assert rst_ mid-drain → all outputs at their reset values next cycle.
